// File: rtl/trace_pkg.sv
// Shared types for the execution trace buffer: stream tags, output FSM states, record layout.
// TRACE_TIMESTAMP_EN adds a per-record cycle timestamp word (tag 3).
package trace_pkg;

    localparam logic [1:0] TAG_PC  = 2'd0;
    localparam logic [1:0] TAG_ULA = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;
    localparam logic [1:0] TAG_TS  = 2'd3;

`ifdef TRACE_TIMESTAMP_EN
    typedef enum logic [2:0] {IDLE, S_PC, S_ULA, S_MEM, S_TS} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ula;
        logic [31:0] mem;
        logic [31:0] ts;
    } trace_rec_t;
`else
    typedef enum logic [1:0] {IDLE, S_PC, S_ULA, S_MEM} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ula;
        logic [31:0] mem;
    } trace_rec_t;
`endif

    localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/exec_trace_buffer_if.sv
// Tagged 32-bit trace word stream with valid/ready handshake.
interface exec_trace_buffer_if;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (output out_data, out_tag, out_valid, out_last, input out_ready);
    modport slave  (input out_data, out_tag, out_valid, out_last, output out_ready);
endinterface

// File: rtl/trace_fifo_mem.sv
// Record FIFO: wrapping pointers, occupancy level, simultaneous push/pop.
// Exposes the head record and the PC of the entry behind it for back-to-back draining.
module trace_fifo_mem
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  trace_rec_t        wr_rec,
    output trace_rec_t        head,
    output logic [31:0]       next_pc,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LVL_MAX = (ADDR_W+1)'(DEPTH);

    trace_rec_t        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_nxt;

    assign rd_nxt  = rd_ptr + PTR_ONE;
    assign head    = mem[rd_ptr];
    assign next_pc = mem[rd_nxt].pc;
    assign full    = (level == LVL_MAX);
    assign empty   = (level == '0);

    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= wr_rec;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/exec_trace_buffer.sv
// Non-intrusive MIPS execution trace: one record per PC change, drained as tagged words.
// TRACE_TIMESTAMP_EN appends a free-running cycle timestamp word to every record.
module exec_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int OVF_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [31:0]         pc_in,
    input  logic [31:0]         ula_in,
    input  logic [31:0]         memdata_in,
    exec_trace_buffer_if.master out_if,
    output logic [ADDR_W:0]     level,
    output logic                full,
    output logic                empty,
    output logic [OVF_W-1:0]    overflow_count
);
    localparam logic [ADDR_W:0] LVL_ONE = (ADDR_W+1)'(1);
    localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);

    state_t      state, nxt_state;
    logic [31:0] data_q, nxt_data;
    logic [1:0]  tag_q, nxt_tag;
    logic        valid_q, nxt_valid, last_q, nxt_last;
    logic [31:0] pc_prev;
    logic        pc_prev_valid;
    logic        capture, push, pop, drop, hs, rec_done;
    trace_rec_t  wr_rec, head;
    logic [31:0] next_pc;

    assign hs      = valid_q && out_if.out_ready;
    assign capture = enable && (!pc_prev_valid || pc_in != pc_prev);
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push    = capture && (!full || pop) && !clear;
    assign drop    = capture && full && !pop && !clear;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 32'd1;
    end
    assign wr_rec = '{pc: pc_in, ula: ula_in, mem: memdata_in, ts: ts_cnt};
`else
    assign wr_rec = '{pc: pc_in, ula: ula_in, mem: memdata_in};
`endif

    trace_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .push    (push),
        .pop     (pop && !clear),
        .wr_rec  (wr_rec),
        .head    (head),
        .next_pc (next_pc),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        nxt_state = state;
        nxt_data  = data_q;
        nxt_tag   = tag_q;
        nxt_valid = valid_q;
        nxt_last  = last_q;
        rec_done  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                nxt_state = S_PC;
                nxt_data  = head.pc;
                nxt_tag   = TAG_PC;
                nxt_valid = 1'b1;
                nxt_last  = 1'b0;
            end
            S_PC: if (hs) begin
                nxt_state = S_ULA;
                nxt_data  = head.ula;
                nxt_tag   = TAG_ULA;
            end
            S_ULA: if (hs) begin
                nxt_state = S_MEM;
                nxt_data  = head.mem;
                nxt_tag   = TAG_MEM;
`ifdef TRACE_TIMESTAMP_EN
                nxt_last  = 1'b0;
`else
                nxt_last  = 1'b1;
`endif
            end
`ifdef TRACE_TIMESTAMP_EN
            S_MEM: if (hs) begin
                nxt_state = S_TS;
                nxt_data  = head.ts;
                nxt_tag   = TAG_TS;
                nxt_last  = 1'b1;
            end
            S_TS: rec_done = hs;
`else
            S_MEM: rec_done = hs;
`endif
            default: nxt_state = IDLE;
        endcase
        // Chain straight into the next record when one is waiting behind the head.
        if (rec_done) begin
            pop = 1'b1;
            if (level > LVL_ONE) begin
                nxt_state = S_PC;
                nxt_data  = next_pc;
                nxt_tag   = TAG_PC;
                nxt_valid = 1'b1;
                nxt_last  = 1'b0;
            end else begin
                nxt_state = IDLE;
                nxt_valid = 1'b0;
                nxt_last  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            data_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            data_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state   <= nxt_state;
            data_q  <= nxt_data;
            tag_q   <= nxt_tag;
            valid_q <= nxt_valid;
            last_q  <= nxt_last;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_prev        <= '0;
            pc_prev_valid  <= 1'b0;
            overflow_count <= '0;
        end else if (clear) begin
            pc_prev_valid  <= 1'b0;
            overflow_count <= '0;
        end else begin
            if (enable) begin
                pc_prev       <= pc_in;
                pc_prev_valid <= 1'b1;
            end
            if (drop && overflow_count != '1) overflow_count <= overflow_count + OVF_ONE;
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_tag   = tag_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
endmodule

// File: tb/tb_exec_trace_buffer.sv
// Scoreboard bench for exec_trace_buffer (default build, 3-word records).
module tb_exec_trace_buffer;
    import trace_pkg::*;

    logic        clock = 1'b0;
    logic        reset, clear, enable;
    logic [31:0] pc_in, ula_in, memdata_in;
    logic [4:0]  level;
    logic        full, empty;
    logic [15:0] overflow_count;
    int          n_vec = 0, n_err = 0;
    logic [34:0] exp_q[$];   // {last, tag, data}

    exec_trace_buffer_if sif ();

    exec_trace_buffer #(.DEPTH(16), .ADDR_W(4), .OVF_W(16)) dut (
        .clock(clock), .reset(reset), .clear(clear), .enable(enable),
        .pc_in(pc_in), .ula_in(ula_in), .memdata_in(memdata_in),
        .out_if(sif), .level(level), .full(full), .empty(empty),
        .overflow_count(overflow_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_rec(input logic [31:0] pc, input logic [31:0] ula, input logic [31:0] mem);
        exp_q.push_back({1'b0, TAG_PC, pc});
        exp_q.push_back({1'b0, TAG_ULA, ula});
        exp_q.push_back({1'b1, TAG_MEM, mem});
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (empty && !sif.out_valid) begin
                ok = 1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (sif.out_valid) begin
                ok = 1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    logic        prev_stall = 1'b0;
    logic [34:0] prev_word;
    always @(negedge clock) begin
        logic [34:0] cur;
        cur = {sif.out_last, sif.out_tag, sif.out_data};
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && sif.out_valid) chk("stall_stable", 64'(cur), 64'(prev_word));
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", 64'(cur), 64'h7_ffff_ffff);
                else chk("stream_word", 64'(cur), 64'(exp_q.pop_front()));
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_word  = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int max_lvl;
        reset = 1'b0; clear = 1'b0; enable = 1'b0;
        pc_in = '0; ula_in = '0; memdata_in = '0; sif.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 64'(sif.out_valid), 64'd0);
        chk("rst_last", 64'(sif.out_last), 64'd0);
        chk("rst_data", 64'(sif.out_data), 64'd0);
        chk("rst_tag", 64'(sif.out_tag), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_empty_full", 64'({empty, full}), 64'b10);
        chk("rst_ovf", 64'(overflow_count), 64'd0);
        tick();
        reset = 1'b1;

        // Two back-to-back records, latency and no bubble between them
        sif.out_ready = 1'b1; enable = 1'b1;
        ula_in = 32'h0000_0010; memdata_in = 32'hDEAD_BEEF;
        pc_in = 32'h0040_0000; expect_rec(32'h0040_0000, 32'h10, 32'hDEAD_BEEF);
        tick();
        pc_in = 32'h0040_0004; expect_rec(32'h0040_0004, 32'h10, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("latency_n", 64'(sif.out_valid), 64'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("no_bubble_valid", 64'(sif.out_valid), 64'd1);
        end
        wait_idle("drain_ab");

        // Held PC gives exactly one record
        tick();
        pc_in = 32'h0040_0008; ula_in = 32'h11; memdata_in = 32'h22;
        expect_rec(32'h0040_0008, 32'h11, 32'h22);
        max_lvl = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        chk("held_pc_peak", 64'(max_lvl), 64'd1);
        wait_idle("drain_held");

        // Overflow: 20 records into 16 entries with the consumer stalled
        tick();
        sif.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pc_in = 32'(i * 4); ula_in = 32'(32'h100 + i); memdata_in = 32'(32'h200 + i);
            if (i < 16) expect_rec(pc_in, ula_in, memdata_in);
            tick();
        end
        @(negedge clock);
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_count", 64'(overflow_count), 64'd4);
        tick();
        sif.out_ready = 1'b1;
        wait_idle("drain_ovf");
        chk("ovf_sb_empty", 64'(exp_q.size()), 64'd0);

        // Stall pattern inside one record
        tick();
        sif.out_ready = 1'b0;
        pc_in = 32'h1000; ula_in = 32'h1001; memdata_in = 32'h1002;
        expect_rec(32'h1000, 32'h1001, 32'h1002);
        wait_valid("stall_wait_valid");
        tick(); sif.out_ready = 1'b1;
        tick(); sif.out_ready = 1'b0;
        tick(); sif.out_ready = 1'b0;
        tick(); sif.out_ready = 1'b1;
        wait_idle("drain_stall");

        // Full FIFO with a push landing on the MEM handshake
        tick();
        sif.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pc_in = 32'(32'h2000 + 4 * i); ula_in = 32'(32'h2100 + i); memdata_in = 32'(32'h2200 + i);
            expect_rec(pc_in, ula_in, memdata_in);
            tick();
        end
        sif.out_ready = 1'b1;
        tick();
        tick();
        pc_in = 32'h3000; ula_in = 32'h31; memdata_in = 32'h32;
        expect_rec(32'h3000, 32'h31, 32'h32);
        tick();
        sif.out_ready = 1'b0;
        @(negedge clock);
        chk("fullpop_level", 64'(level), 64'd16);
        chk("fullpop_full", 64'(full), 64'd1);
        chk("fullpop_ovf", 64'(overflow_count), 64'd4);
        tick();
        sif.out_ready = 1'b1;
        wait_idle("drain_fullpop");
        chk("fullpop_sb_empty", 64'(exp_q.size()), 64'd0);

        // Clear flushes everything; held PC is recaptured afterwards
        tick();
        sif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(32'h5000 + 4 * i); tick();
        end
        clear = 1'b1; tick(); clear = 1'b0;
        @(negedge clock);
        chk("clr_level", 64'(level), 64'd0);
        chk("clr_empty", 64'(empty), 64'd1);
        chk("clr_ovf", 64'(overflow_count), 64'd0);
        chk("clr_valid", 64'(sif.out_valid), 64'd0);
        expect_rec(32'h5008, ula_in, memdata_in);
        tick();
        sif.out_ready = 1'b1;
        wait_idle("drain_clr");

        // Reset in the middle of a record with 5 entries queued
        tick();
        sif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_in = 32'(32'h6000 + 4 * i); ula_in = 32'(i); memdata_in = 32'(i);
            expect_rec(pc_in, ula_in, memdata_in);
            tick();
        end
        sif.out_ready = 1'b1; tick(); sif.out_ready = 1'b0;
        enable = 1'b0;
        @(negedge clock);
        chk("pre_rst_tag", 64'(sif.out_tag), 64'(TAG_ULA));
        chk("pre_rst_level", 64'(level), 64'd5);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(sif.out_valid), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_ovf", 64'(overflow_count), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        sif.out_ready = 1'b1;
        repeat (10) @(negedge clock);
        chk("post_rst_valid", 64'(sif.out_valid), 64'd0);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exec_trace_buffer.md
Name: exec_trace_buffer

Overview:
- Downstream observer of the top-level MIPS core; consumes PC_out, ULA_out and MemData_out each clock.
- Captures one record per executed instruction (detected as a PC change) into a FIFO.
- Drains each record as a sequence of tagged 32-bit words over a valid/ready stream, for a UART or debug host.
- Gives the multicycle core a non-intrusive execution trace.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 4, log2(DEPTH).
- OVF_W, 16, overflow counter width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; priority over all other activity.
- enable  in  1  capture enable.
- pc_in  in  32  from PC_out.
- ula_in  in  32  from ULA_out.
- memdata_in  in  32  from MemData_out.
- out_data  out  32  current stream word.
- out_tag  out  2  word type: 0=PC, 1=ULA, 2=MEM, 3=TS.
- out_valid  out  1  out_data/out_tag/out_last are valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  last word of the record.
- level  out  ADDR_W+1  occupied entries.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow_count  out  OVF_W  dropped records; saturates.

Behaviour:
- Reset (reset=0, asynchronous): out_data=0, out_tag=0, out_valid=0, out_last=0, level=0, full=0, empty=1, overflow_count=0, FSM=IDLE, pc_prev=0, pc_prev_valid=0.
- Reset mid-stream discards the partial record; no word is re-emitted after release.
- Capture condition, evaluated each cycle: enable && (!pc_prev_valid || pc_in != pc_prev).
- pc_prev and pc_prev_valid update whenever enable=1, including when the record is dropped.
- Record = {pc_in, ula_in, memdata_in}, sampled in the capture cycle.
- Push if !full, or if full and a pop occurs in the same cycle.
- Otherwise the record is dropped and overflow_count increments, saturating at all-ones.
- Pop happens on the handshake (out_valid && out_ready) of the word with out_last=1.
- Simultaneous push and pop: level unchanged.
- Pointers wrap modulo DEPTH.
- FSM states IDLE, S_PC, S_ULA, S_MEM.
- IDLE -> S_PC when !empty; load head PC into out_data, set out_tag=0, out_valid=1.
- Latency: a push at edge N gives out_valid=1 after edge N+1.
- Each handshake advances S_PC -> S_ULA -> S_MEM. out_last=1 only in S_MEM.
- After the S_MEM handshake: go to S_PC with no bubble if entries remain after the pop; otherwise go to IDLE with out_valid=0.
- While out_valid && !out_ready, out_data, out_tag and out_last hold stable.
- Words of one record are never interleaved with another record.
- clear=1: FIFO empty, overflow_count=0, FSM=IDLE, out_valid=0, pc_prev_valid=0. Any push or pop in that cycle is ignored.
- enable=0 blocks capture only; draining continues.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined: a 32-bit free-running cycle counter resets to 0, wraps, and is not affected by clear. Its value is stored per record. The FSM adds S_TS after S_MEM, emitting the value with out_tag=3. out_last moves to S_TS, and the pop occurs on the S_TS handshake.
- Undefined: no counter and no S_TS; records are 3 words and tag 3 is never emitted.

Decomposition:
- Package trace_pkg: TAG_PC/TAG_ULA/TAG_MEM/TAG_TS constants, FSM state encoding, record width (96 or 128 bits under the macro).
- Sub-module trace_fifo_mem: synchronous FIFO holding storage, wrapping pointers, level/full/empty and simultaneous push/pop handling.
- The top block holds the capture logic, overflow counter and output FSM.

Test Plan:
- Assert reset=0 during an S_ULA word with level=5 -> same cycle: out_valid=0, level=0, empty=1, overflow_count=0; after release, no stale words appear.
- enable=1, pc 0x00400000 then 0x00400004 (ula=0x00000010, mem=0xDEADBEEF in each capture cycle), out_ready=1 -> stream for record 0 is 0x00400000/t0, 0x00000010/t1, 0xDEADBEEF/t2 with last=1; record 1 follows with no idle cycle.
- PC held at 0x00400008 for 6 cycles -> exactly one record; level peaks at 1.
- out_ready=0, 20 distinct PCs 0x0..0x4C step 4 -> level=16, full=1, overflow_count=4. Then out_ready=1 -> 48 words; first PC=0x0, last PC=0x3C.
- out_ready toggled 1,0,0,1 during a record -> out_data/out_tag stable while stalled; no word skipped or duplicated.
- full=1, a new PC arrives in the same cycle as the S_MEM handshake -> push accepted, level stays 16, overflow_count unchanged.
